// File: rtl/memory_reader.sv
// Single-outstanding Avalon-MM read engine: latches a cache-side request, issues one
// memory read, waits for data or a timeout, and answers only if the request is still live.
package memory_reader_pkg;
  typedef logic [31:0] regval_t;
endpackage

module memory_reader
  import memory_reader_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        input_address_enable,
  input  regval_t     input_address,
  output logic        output_data_valid,
  output regval_t     output_data,
  output logic        mem_read,
  output logic [31:0] mem_address,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  input  logic [31:0] mem_readdata,
  output logic        timeout_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_e;

  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        mem_read_q, mem_read_d;
  regval_t     data_q, data_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        addr_match_s;
  logic        unused_addr_lsb_s;

  assign addr_match_s      = (input_address[31:2] == addr_q[31:2]);
  assign unused_addr_lsb_s = ^input_address[1:0];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_read_d = mem_read_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: begin
        if (input_address_enable) begin
          addr_d     = {input_address[31:2], 2'b00};
          mem_read_d = 1'b1;
          state_d    = REQUEST;
        end else begin
          mem_read_d = 1'b0;
        end
      end
      REQUEST: begin
        // Acceptance wins over a same-cycle withdrawal: once taken, the read is owed.
        if (!mem_waitrequest) begin
          mem_read_d = 1'b0;
          cnt_d      = 16'd0;
          state_d    = WAIT;
        end else if (!input_address_enable) begin
          mem_read_d = 1'b0;
          state_d    = IDLE;
        end else begin
          mem_read_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_readdatavalid) begin
          data_d  = mem_readdata;
          state_d = RESPOND;
        end else if (({1'b0, cnt_q} + 17'd1) >= TIMEOUT_L) begin
          data_d    = 32'd0;
          timeout_d = 1'b1;
          state_d   = RESPOND;
        end else begin
          state_d = WAIT;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        mem_read_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      mem_read_q <= 1'b0;
      data_q     <= 32'd0;
      cnt_q      <= 16'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_read_q <= mem_read_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // The response is qualified by the requester's live enable/address in the RESPOND cycle.
  assign output_data_valid = (state_q == RESPOND) && input_address_enable && addr_match_s;
  assign output_data       = data_q;
  assign mem_read          = mem_read_q;
  assign mem_address       = addr_q;
  assign timeout_error     = timeout_q;

endmodule

// File: tb/tb_memory_reader.sv
// Directed bench for memory_reader with TIMEOUT=4; memory side is driven by hand.
module tb_memory_reader;

  logic        clock;
  logic        reset_n;
  logic        input_address_enable;
  logic [31:0] input_address;
  logic        output_data_valid;
  logic [31:0] output_data;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        mem_waitrequest;
  logic        mem_readdatavalid;
  logic [31:0] mem_readdata;
  logic        timeout_error;

  int checks = 0;
  int errors = 0;
  int accept_cnt = 0;
  int acc_base;

  memory_reader #(.TIMEOUT(4)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .input_address_enable(input_address_enable),
    .input_address       (input_address),
    .output_data_valid   (output_data_valid),
    .output_data         (output_data),
    .mem_read            (mem_read),
    .mem_address         (mem_address),
    .mem_waitrequest     (mem_waitrequest),
    .mem_readdatavalid   (mem_readdatavalid),
    .mem_readdata        (mem_readdata),
    .timeout_error       (timeout_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset_n && mem_read && !mem_waitrequest) accept_cnt <= accept_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    input_address_enable = 1'b0;
    input_address = 32'd0;
    mem_waitrequest = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata = 32'd0;
    step(); step();
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_valid", {31'd0, output_data_valid}, 32'd0);
    check("rst_data", output_data, 32'd0);
    check("rst_timeout", {31'd0, timeout_error}, 32'd0);
    reset_n = 1'b1;
    step();

    // Basic read
    input_address_enable = 1'b1; input_address = 32'h0000_1006; #1;
    check("basic_c0_read", {31'd0, mem_read}, 32'd0);
    step();
    check("basic_c1_read", {31'd0, mem_read}, 32'd1);
    check("basic_c1_addr", mem_address, 32'h0000_1004);
    step();
    check("basic_c2_read", {31'd0, mem_read}, 32'd0);
    mem_readdatavalid = 1'b1; mem_readdata = 32'hDEAD_BEEF; #1;
    check("basic_c2_valid", {31'd0, output_data_valid}, 32'd0);
    step();
    mem_readdatavalid = 1'b0; #1;
    check("basic_c3_valid", {31'd0, output_data_valid}, 32'd1);
    check("basic_c3_data", output_data, 32'hDEAD_BEEF);
    step();
    input_address_enable = 1'b0; #1;
    check("basic_c4_valid", {31'd0, output_data_valid}, 32'd0);
    step();

    // Stall: waitrequest high for 5 REQUEST cycles
    acc_base = accept_cnt;
    input_address_enable = 1'b1; input_address = 32'h0000_0200; mem_waitrequest = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_read", {31'd0, mem_read}, 32'd1);
      check("stall_addr", mem_address, 32'h0000_0200);
      step();
    end
    mem_waitrequest = 1'b0; #1;
    check("stall_read6", {31'd0, mem_read}, 32'd1);
    check("stall_addr6", mem_address, 32'h0000_0200);
    step();
    check("stall_read_off", {31'd0, mem_read}, 32'd0);
    mem_readdatavalid = 1'b1; mem_readdata = 32'h1234_5678;
    step();
    mem_readdatavalid = 1'b0; #1;
    check("stall_valid", {31'd0, output_data_valid}, 32'd1);
    check("stall_data", output_data, 32'h1234_5678);
    check("stall_accepts", accept_cnt - acc_base, 32'd1);
    step();
    input_address_enable = 1'b0;
    step();

    // Withdrawal in REQUEST before acceptance
    acc_base = accept_cnt;
    input_address_enable = 1'b1; input_address = 32'h0000_0400; mem_waitrequest = 1'b1;
    step();
    check("wdreq_read", {31'd0, mem_read}, 32'd1);
    input_address_enable = 1'b0;
    step();
    check("wdreq_read_off", {31'd0, mem_read}, 32'd0);
    mem_waitrequest = 1'b0;
    step();
    check("wdreq_read_idle", {31'd0, mem_read}, 32'd0);
    check("wdreq_accepts", accept_cnt - acc_base, 32'd0);

    // Withdrawal in WAIT, data 3 cycles later
    input_address_enable = 1'b1; input_address = 32'h0000_0300;
    step();
    step();
    input_address_enable = 1'b0;
    step(); step(); step();
    mem_readdatavalid = 1'b1; mem_readdata = 32'hBAD0_0300; #1;
    check("wdwait_valid_c5", {31'd0, output_data_valid}, 32'd0);
    step();
    mem_readdatavalid = 1'b0; #1;
    check("wdwait_valid_c6", {31'd0, output_data_valid}, 32'd0);
    step();
    input_address_enable = 1'b1; input_address = 32'h0000_0020;
    step();
    check("wdwait_new_read", {31'd0, mem_read}, 32'd1);
    check("wdwait_new_addr", mem_address, 32'h0000_0020);
    step();
    mem_readdatavalid = 1'b1; mem_readdata = 32'hCAFE_0020;
    step();
    mem_readdatavalid = 1'b0; #1;
    check("wdwait_new_valid", {31'd0, output_data_valid}, 32'd1);
    check("wdwait_new_data", output_data, 32'hCAFE_0020);
    check("wdwait_no_timeout", {31'd0, timeout_error}, 32'd0);
    step();
    input_address_enable = 1'b0;
    step();

    // Address change during WAIT
    input_address_enable = 1'b1; input_address = 32'h0000_0010;
    step();
    step();
    input_address = 32'h0000_0040;
    step();
    mem_readdatavalid = 1'b1; mem_readdata = 32'h1111_0010;
    step();
    mem_readdatavalid = 1'b0; #1;
    check("achg_drop", {31'd0, output_data_valid}, 32'd0);
    step();
    step();
    check("achg_read", {31'd0, mem_read}, 32'd1);
    check("achg_addr", mem_address, 32'h0000_0040);
    step();
    mem_readdatavalid = 1'b1; mem_readdata = 32'h4444_0040;
    step();
    mem_readdatavalid = 1'b0; #1;
    check("achg_valid", {31'd0, output_data_valid}, 32'd1);
    check("achg_data", output_data, 32'h4444_0040);
    step();
    input_address_enable = 1'b0;
    step();

    // Timeout with TIMEOUT=4
    input_address_enable = 1'b1; input_address = 32'h0000_0500;
    step();
    step();
    step(); step(); step();
    check("to_not_yet_valid", {31'd0, output_data_valid}, 32'd0);
    check("to_not_yet_err", {31'd0, timeout_error}, 32'd0);
    step();
    check("to_valid", {31'd0, output_data_valid}, 32'd1);
    check("to_data", output_data, 32'd0);
    check("to_err", {31'd0, timeout_error}, 32'd1);
    step();
    input_address_enable = 1'b0;
    step();
    mem_readdatavalid = 1'b1; mem_readdata = 32'h5555_5555; #1;
    check("to_late_valid", {31'd0, output_data_valid}, 32'd0);
    step();
    mem_readdatavalid = 1'b0; #1;
    check("to_late_valid2", {31'd0, output_data_valid}, 32'd0);
    check("to_late_data", output_data, 32'd0);
    check("to_sticky", {31'd0, timeout_error}, 32'd1);
    step();

    // Reset mid-WAIT
    input_address_enable = 1'b1; input_address = 32'h0000_0600;
    step();
    step();
    reset_n = 1'b0;
    step();
    check("rw_read", {31'd0, mem_read}, 32'd0);
    check("rw_addr", mem_address, 32'd0);
    check("rw_valid", {31'd0, output_data_valid}, 32'd0);
    check("rw_data", output_data, 32'd0);
    check("rw_timeout", {31'd0, timeout_error}, 32'd0);
    reset_n = 1'b1; input_address_enable = 1'b0;
    mem_readdatavalid = 1'b1; mem_readdata = 32'h7777_7777;
    step();
    mem_readdatavalid = 1'b0; #1;
    check("rw_stray_valid", {31'd0, output_data_valid}, 32'd0);
    check("rw_stray_data", output_data, 32'd0);
    check("rw_stray_read", {31'd0, mem_read}, 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
